// File: rtl/counter_bank_if.sv
// Counter bank control/status bundle: per-channel strobes and operands in, registered counts and flags out.
// Master drives the controls; the counter bank (slave) drives q_o, overflow_o and match_o.
interface counter_bank_if #(
  parameter int NUM_CNT = 4,
  parameter int WIDTH   = 16
);
  logic [NUM_CNT-1:0]            clear_i;
  logic [NUM_CNT-1:0]            load_i;
  logic [NUM_CNT-1:0]            en_i;
  logic [NUM_CNT-1:0]            down_i;
  logic [NUM_CNT-1:0]            reload_en_i;
  logic [NUM_CNT-1:0][WIDTH-1:0] delta_i;
  logic [NUM_CNT-1:0][WIDTH-1:0] d_i;
  logic [NUM_CNT-1:0][WIDTH-1:0] cmp_i;
  logic [NUM_CNT-1:0][WIDTH-1:0] q_o;
  logic [NUM_CNT-1:0]            overflow_o;
  logic [NUM_CNT-1:0]            match_o;

  modport master (
    output clear_i, load_i, en_i, down_i, reload_en_i, delta_i, d_i, cmp_i,
    input  q_o, overflow_o, match_o
  );

  modport slave (
    input  clear_i, load_i, en_i, down_i, reload_en_i, delta_i, d_i, cmp_i,
    output q_o, overflow_o, match_o
  );
endinterface

// File: rtl/counter_bank.sv
// Bank of independent up/down counters with load, compare-match, auto-reload and wrap/saturate overflow.
// Latency: one cycle, all outputs registered; no backpressure, every strobe is accepted each cycle.
module counter_bank #(
  parameter int       NUM_CNT         = 4,
  parameter int       WIDTH           = 16,
  parameter bit       STICKY_OVERFLOW = 1'b0,
  parameter bit       SATURATE        = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  counter_bank_if.slave bus
);

  logic [NUM_CNT-1:0][WIDTH-1:0] q_r;
  logic [NUM_CNT-1:0]            ovf_r;
  logic [NUM_CNT-1:0]            match_r;

  assign bus.q_o        = q_r;
  assign bus.overflow_o = ovf_r;
  assign bus.match_o    = match_r;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_chan
    logic [WIDTH:0]   step_sum;
    logic             carry;
    logic [WIDTH-1:0] stepped;
    logic             hit;
    logic [WIDTH-1:0] q_nxt;
    logic             ovf_nxt;
    logic             match_nxt;

    always_comb begin
      step_sum  = '0;
      stepped   = '0;
      carry     = 1'b0;
      hit       = 1'b0;
      q_nxt     = q_r[g];
      ovf_nxt   = ovf_r[g];
      match_nxt = 1'b0;

      // Extra MSB of the step result is carry when counting up, borrow when counting down.
      if (bus.down_i[g]) begin
        step_sum = {1'b0, q_r[g]} - {1'b0, bus.delta_i[g]};
      end else begin
        step_sum = {1'b0, q_r[g]} + {1'b0, bus.delta_i[g]};
      end
      carry = step_sum[WIDTH];

      if (SATURATE && carry) begin
        stepped = bus.down_i[g] ? '0 : {WIDTH{1'b1}};
      end else begin
        stepped = step_sum[WIDTH-1:0];
      end
      hit = (stepped == bus.cmp_i[g]);

      if (bus.clear_i[g]) begin
        q_nxt   = '0;
        ovf_nxt = 1'b0;
      end else if (bus.load_i[g]) begin
        q_nxt   = bus.d_i[g];
        ovf_nxt = 1'b0;
      end else if (bus.en_i[g]) begin
        q_nxt     = (hit && bus.reload_en_i[g]) ? bus.d_i[g] : stepped;
        match_nxt = hit;
        if (carry) begin
          ovf_nxt = 1'b1;
        end else if (!STICKY_OVERFLOW) begin
          ovf_nxt = 1'b0;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q_r[g]     <= '0;
        ovf_r[g]   <= 1'b0;
        match_r[g] <= 1'b0;
      end else begin
        q_r[g]     <= q_nxt;
        ovf_r[g]   <= ovf_nxt;
        match_r[g] <= match_nxt;
      end
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: wrap, saturate and sticky-overflow instances share clock and reset.
module tb_counter_bank;
  localparam int N = 2;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  counter_bank_if #(.NUM_CNT(N), .WIDTH(W)) if_w ();
  counter_bank_if #(.NUM_CNT(N), .WIDTH(W)) if_s ();
  counter_bank_if #(.NUM_CNT(N), .WIDTH(W)) if_k ();

  counter_bank #(.NUM_CNT(N), .WIDTH(W), .STICKY_OVERFLOW(1'b0), .SATURATE(1'b0))
    dut_wrap (.clk_i(clk), .rst_ni(rst_n), .bus(if_w));
  counter_bank #(.NUM_CNT(N), .WIDTH(W), .STICKY_OVERFLOW(1'b0), .SATURATE(1'b1))
    dut_sat (.clk_i(clk), .rst_ni(rst_n), .bus(if_s));
  counter_bank #(.NUM_CNT(N), .WIDTH(W), .STICKY_OVERFLOW(1'b1), .SATURATE(1'b0))
    dut_sticky (.clk_i(clk), .rst_ni(rst_n), .bus(if_k));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_w.clear_i = '0; if_w.load_i = '0; if_w.en_i = '0; if_w.down_i = '0; if_w.reload_en_i = '0;
    if_s.clear_i = '0; if_s.load_i = '0; if_s.en_i = '0; if_s.down_i = '0; if_s.reload_en_i = '0;
    if_k.clear_i = '0; if_k.load_i = '0; if_k.en_i = '0; if_k.down_i = '0; if_k.reload_en_i = '0;
  endtask

  task automatic test_reset();
    // Reset asserted between edges: outputs must already be zero with no edge seen.
    #1 rst_n = 1'b0;
    #1;
    checks++; if (if_w.q_o !== '0 || if_w.overflow_o !== '0 || if_w.match_o !== '0)
      $display("FAIL reset_wrap q=%h ovf=%b match=%b exp all 0", if_w.q_o, if_w.overflow_o, if_w.match_o); else passed++;
    checks++; if (if_s.q_o !== '0 || if_s.overflow_o !== '0 || if_s.match_o !== '0)
      $display("FAIL reset_sat q=%h ovf=%b match=%b exp all 0", if_s.q_o, if_s.overflow_o, if_s.match_o); else passed++;
    checks++; if (if_k.q_o !== '0 || if_k.overflow_o !== '0 || if_k.match_o !== '0)
      $display("FAIL reset_sticky q=%h ovf=%b match=%b exp all 0", if_k.q_o, if_k.overflow_o, if_k.match_o); else passed++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    idle_all();
    if_w.cmp_i[0] = 4'd9;
    if_w.d_i[0]   = 4'd14;
    if_w.load_i[0] = 1'b1;
    tick();
    checks++; if (if_w.q_o[0] !== 4'd14 || if_w.overflow_o[0] !== 1'b0)
      $display("FAIL wrap_load q=%0d ovf=%b exp q=14 ovf=0", if_w.q_o[0], if_w.overflow_o[0]); else passed++;
    if_w.load_i[0] = 1'b0;
    if_w.en_i[0] = 1'b1; if_w.delta_i[0] = 4'd3;
    tick();
    checks++; if (if_w.q_o[0] !== 4'd1 || if_w.overflow_o[0] !== 1'b1)
      $display("FAIL wrap_carry q=%0d ovf=%b exp q=1 ovf=1", if_w.q_o[0], if_w.overflow_o[0]); else passed++;
    if_w.delta_i[0] = 4'd1;
    tick();
    checks++; if (if_w.q_o[0] !== 4'd2 || if_w.overflow_o[0] !== 1'b0)
      $display("FAIL wrap_nocarry q=%0d ovf=%b exp q=2 ovf=0", if_w.q_o[0], if_w.overflow_o[0]); else passed++;
    // 2 - 3 borrows and wraps to 15.
    if_w.down_i[0] = 1'b1; if_w.delta_i[0] = 4'd3;
    tick();
    checks++; if (if_w.q_o[0] !== 4'd15 || if_w.overflow_o[0] !== 1'b1)
      $display("FAIL wrap_borrow q=%0d ovf=%b exp q=15 ovf=1", if_w.q_o[0], if_w.overflow_o[0]); else passed++;
    idle_all();
    tick();
    checks++; if (if_w.q_o[0] !== 4'd15 || if_w.overflow_o[0] !== 1'b1 || if_w.match_o[0] !== 1'b0)
      $display("FAIL wrap_hold q=%0d ovf=%b m=%b exp q=15 ovf=1 m=0", if_w.q_o[0], if_w.overflow_o[0], if_w.match_o[0]); else passed++;
  endtask

  task automatic test_saturate();
    idle_all();
    if_s.cmp_i[0] = 4'd9;
    if_s.d_i[0] = 4'd2; if_s.load_i[0] = 1'b1;
    tick();
    if_s.load_i[0] = 1'b0;
    if_s.en_i[0] = 1'b1; if_s.down_i[0] = 1'b1; if_s.delta_i[0] = 4'd5;
    tick();
    checks++; if (if_s.q_o[0] !== 4'd0 || if_s.overflow_o[0] !== 1'b1)
      $display("FAIL sat_floor q=%0d ovf=%b exp q=0 ovf=1", if_s.q_o[0], if_s.overflow_o[0]); else passed++;
    if_s.down_i[0] = 1'b0; if_s.delta_i[0] = 4'd4;
    tick();
    checks++; if (if_s.q_o[0] !== 4'd4 || if_s.overflow_o[0] !== 1'b0)
      $display("FAIL sat_up q=%0d ovf=%b exp q=4 ovf=0", if_s.q_o[0], if_s.overflow_o[0]); else passed++;
    // 4 + 13 carries: clamp at all-ones.
    if_s.delta_i[0] = 4'd13;
    tick();
    checks++; if (if_s.q_o[0] !== 4'd15 || if_s.overflow_o[0] !== 1'b1)
      $display("FAIL sat_ceiling q=%0d ovf=%b exp q=15 ovf=1", if_s.q_o[0], if_s.overflow_o[0]); else passed++;
    idle_all();
  endtask

  task automatic test_sticky();
    idle_all();
    if_k.cmp_i[0] = 4'd15;
    if_k.d_i[0] = 4'd15; if_k.load_i[0] = 1'b1;
    tick();
    if_k.load_i[0] = 1'b0;
    if_k.en_i[0] = 1'b1; if_k.delta_i[0] = 4'd1;
    tick();
    checks++; if (if_k.q_o[0] !== 4'd0 || if_k.overflow_o[0] !== 1'b1)
      $display("FAIL sticky_set q=%0d ovf=%b exp q=0 ovf=1", if_k.q_o[0], if_k.overflow_o[0]); else passed++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (if_k.q_o[0] !== W'(i) || if_k.overflow_o[0] !== 1'b1)
        $display("FAIL sticky_hold%0d q=%0d ovf=%b exp q=%0d ovf=1", i, if_k.q_o[0], if_k.overflow_o[0], i); else passed++;
    end
    if_k.en_i[0] = 1'b0;
    if_k.d_i[0] = 4'd0; if_k.load_i[0] = 1'b1;
    tick();
    checks++; if (if_k.q_o[0] !== 4'd0 || if_k.overflow_o[0] !== 1'b0)
      $display("FAIL sticky_load_clr q=%0d ovf=%b exp q=0 ovf=0", if_k.q_o[0], if_k.overflow_o[0]); else passed++;
    idle_all();
  endtask

  task automatic test_timer();
    logic [W-1:0] exp_q [8];
    logic         exp_m [8];
    exp_q = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
    exp_m = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    idle_all();
    if_w.d_i[0] = 4'd0; if_w.cmp_i[0] = 4'd3; if_w.load_i[0] = 1'b1;
    tick();
    if_w.load_i[0] = 1'b0;
    if_w.reload_en_i[0] = 1'b1; if_w.en_i[0] = 1'b1; if_w.delta_i[0] = 4'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (if_w.q_o[0] !== exp_q[i] || if_w.match_o[0] !== exp_m[i])
        $display("FAIL timer_c%0d q=%0d m=%b exp q=%0d m=%b", i, if_w.q_o[0], if_w.match_o[0], exp_q[i], exp_m[i]); else passed++;
    end
    idle_all();
    tick();
    checks++; if (if_w.match_o[0] !== 1'b0 || if_w.q_o[0] !== 4'd2)
      $display("FAIL timer_idle q=%0d m=%b exp q=2 m=0", if_w.q_o[0], if_w.match_o[0]); else passed++;
  endtask

  task automatic test_load_and_zero_delta();
    idle_all();
    // A load landing on cmp must not pulse match.
    if_w.d_i[0] = 4'd3; if_w.cmp_i[0] = 4'd3; if_w.load_i[0] = 1'b1;
    tick();
    checks++; if (if_w.q_o[0] !== 4'd3 || if_w.match_o[0] !== 1'b0)
      $display("FAIL load_nomatch q=%0d m=%b exp q=3 m=0", if_w.q_o[0], if_w.match_o[0]); else passed++;
    if_w.load_i[0] = 1'b0;
    if_w.en_i[0] = 1'b1; if_w.delta_i[0] = 4'd0;
    tick();
    checks++; if (if_w.q_o[0] !== 4'd3 || if_w.match_o[0] !== 1'b1 || if_w.overflow_o[0] !== 1'b0)
      $display("FAIL zero_delta q=%0d m=%b ovf=%b exp q=3 m=1 ovf=0", if_w.q_o[0], if_w.match_o[0], if_w.overflow_o[0]); else passed++;
    if_w.en_i[0] = 1'b0; if_w.clear_i[0] = 1'b1; if_w.cmp_i[0] = 4'd0;
    tick();
    checks++; if (if_w.q_o[0] !== 4'd0 || if_w.match_o[0] !== 1'b0)
      $display("FAIL clear_nomatch q=%0d m=%b exp q=0 m=0", if_w.q_o[0], if_w.match_o[0]); else passed++;
    idle_all();
  endtask

  task automatic test_priority_and_mid_reset();
    idle_all();
    if_w.cmp_i[0] = 4'd15; if_w.cmp_i[1] = 4'd15;
    if_w.d_i[0] = 4'd5; if_w.d_i[1] = 4'd9; if_w.load_i = 2'b11;
    tick();
    if_w.load_i = 2'b00;
    if_w.en_i[0] = 1'b1; if_w.delta_i[0] = 4'd2;
    if_w.d_i[1] = 4'd7; if_w.delta_i[1] = 4'd1;
    if_w.clear_i[1] = 1'b1; if_w.load_i[1] = 1'b1; if_w.en_i[1] = 1'b1;
    tick();
    checks++; if (if_w.q_o[1] !== 4'd0 || if_w.q_o[0] !== 4'd7)
      $display("FAIL prio_clear ch1=%0d ch0=%0d exp ch1=0 ch0=7", if_w.q_o[1], if_w.q_o[0]); else passed++;
    if_w.clear_i[1] = 1'b0;
    tick();
    checks++; if (if_w.q_o[1] !== 4'd7 || if_w.q_o[0] !== 4'd9)
      $display("FAIL prio_load ch1=%0d ch0=%0d exp ch1=7 ch0=9", if_w.q_o[1], if_w.q_o[0]); else passed++;
    // Reset mid-count, between edges, with strobes still driven.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if_w.q_o !== '0 || if_w.overflow_o !== '0 || if_w.match_o !== '0)
      $display("FAIL midreset_wrap q=%h ovf=%b m=%b exp all 0", if_w.q_o, if_w.overflow_o, if_w.match_o); else passed++;
    checks++; if (if_s.q_o !== '0 || if_k.q_o !== '0 || if_s.overflow_o !== '0 || if_k.overflow_o !== '0)
      $display("FAIL midreset_others sq=%h kq=%h sovf=%b kovf=%b exp all 0", if_s.q_o, if_k.q_o, if_s.overflow_o, if_k.overflow_o); else passed++;
    #1 rst_n = 1'b1;
    tick();
    checks++; if (if_w.q_o[0] !== 4'd2 || if_w.q_o[1] !== 4'd7)
      $display("FAIL post_reset ch0=%0d ch1=%0d exp ch0=2 ch1=7", if_w.q_o[0], if_w.q_o[1]); else passed++;
    idle_all();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n  = 1'b1;
    idle_all();
    for (int c = 0; c < N; c++) begin
      if_w.delta_i[c] = '0; if_w.d_i[c] = '0; if_w.cmp_i[c] = 4'd15;
      if_s.delta_i[c] = '0; if_s.d_i[c] = '0; if_s.cmp_i[c] = 4'd15;
      if_k.delta_i[c] = '0; if_k.d_i[c] = '0; if_k.cmp_i[c] = 4'd15;
    end
    test_reset();
    test_wrap();
    test_saturate();
    test_sticky();
    test_timer();
    test_load_and_zero_delta();
    test_priority_and_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 The block SHALL have parameter NUM_CNT, default 4, meaning the number of independent counter channels (>=1).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning the counter width in bits (>=2).
REQ-003 The block SHALL have parameter STICKY_OVERFLOW, default 1'b0, meaning overflow flags hold until a clear or load.
REQ-004 The block SHALL have parameter SATURATE, default 1'b0, meaning steps clamp at 0 or 2^WIDTH-1 instead of wrapping.
REQ-005 The block SHALL have port clk_i, input, width 1, the single clock; all state SHALL change on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, width 1, the asynchronous active-low reset.
REQ-007 The block SHALL have port clear_i, input, width NUM_CNT, the per-channel synchronous clear.
REQ-008 The block SHALL have port load_i, input, width NUM_CNT, the per-channel load strobe.
REQ-009 The block SHALL have port en_i, input, width NUM_CNT, the per-channel step enable.
REQ-010 The block SHALL have port down_i, input, width NUM_CNT, the per-channel direction (1 = down).
REQ-011 The block SHALL have port reload_en_i, input, width NUM_CNT, the per-channel auto-reload on match.
REQ-012 The block SHALL have ports delta_i, d_i and cmp_i, input, each NUM_CNT x WIDTH, giving per-channel step size, load/reload value and compare value.
REQ-013 The block SHALL have port q_o, output, NUM_CNT x WIDTH, the registered count values.
REQ-014 The block SHALL have port overflow_o, output, width NUM_CNT, the registered overflow/underflow flags.
REQ-015 The block SHALL have port match_o, output, width NUM_CNT, a registered one-cycle compare-match pulse.

Function
REQ-016 Channels SHALL be fully independent; no input of channel i SHALL affect any output of channel j != i.
REQ-017 Per-channel priority SHALL be clear_i > load_i > en_i; with none asserted, q, overflow and match (match->0) SHALL hold.
REQ-018 clear_i SHALL set q to 0, overflow to 0 and match to 0 on the next edge.
REQ-019 load_i SHALL set q to d_i, overflow to 0 and match to 0 on the next edge.
REQ-020 An enabled step SHALL compute q+delta_i (down_i=0) or q-delta_i (down_i=1) at WIDTH+1 bits; the extra bit is carry/borrow.
REQ-021 With SATURATE=0, the next q SHALL be the low WIDTH bits of the step result (modulo wrap).
REQ-022 With SATURATE=1, a carry SHALL give q = 2^WIDTH-1 and a borrow SHALL give q = 0.
REQ-023 A step with carry/borrow SHALL set overflow to 1 in both modes.
REQ-024 With STICKY_OVERFLOW=0, a step without carry/borrow SHALL set overflow to 0; with STICKY_OVERFLOW=1 it SHALL leave overflow unchanged.
REQ-025 delta_i = 0 with en_i SHALL leave q unchanged, count as a step without carry/borrow, and evaluate match normally.
REQ-026 match SHALL be 1 for exactly the cycle after an enabled step whose post-wrap/post-saturation result equals cmp_i; otherwise match SHALL be 0.
REQ-027 On such a match with reload_en_i=1, the next q SHALL be d_i instead of the step result; overflow SHALL still follow REQ-023/024.
REQ-028 Loads and clears SHALL never produce match, even when the resulting value equals cmp_i.
REQ-029 All outputs SHALL come directly from registers; the block SHALL have no combinational input-to-output paths.

Reset
REQ-030 Asserting rst_ni low SHALL immediately, without a clock edge, force all q_o to 0, all overflow_o to 0 and all match_o to 0.
REQ-031 Reset asserted mid-operation SHALL discard any in-progress step; the first edge after deassertion SHALL apply the normal priority rules.

Verification
REQ-032 WIDTH=4, wrap, ch0: load 14, en up delta 3 -> q=1, overflow=1; next en delta 1 -> q=2, overflow=0.
REQ-033 WIDTH=4, SATURATE=1: load 2, en down delta 5 -> q=0, overflow=1; en up delta 20 mod 16 (=4) -> q=4, overflow=0.
REQ-034 STICKY_OVERFLOW=1: force overflow, then 3 non-overflowing steps -> overflow stays 1; load 0 -> overflow=0.
REQ-035 Timer mode: d=0, cmp=3, reload_en=1, en up delta 1 for 8 cycles -> q sequence 1,2,0,1,2,0,1,2 with match pulse after each reload.
REQ-036 Same edge clear+load+en on ch1 with ch0 stepping -> ch1 q=0, ch0 unaffected; rst_ni low mid-count -> all outputs 0 without a clock edge.
